// File: rtl/dfifo_pkg.sv
// dfifo_pkg -- shared definitions for the synchronous FIFO with water level.
// Holds the depth / level-width derivation functions and the legal ranges of
// the FIFO parameters, plus a single predicate used by the top level to
// reject illegal parameter sets at elaboration time.
package dfifo_pkg;

  localparam int DFIFO_DW_MIN = 1;
  localparam int DFIFO_DW_MAX = 256;
  localparam int DFIFO_AW_MIN = 4;
  localparam int DFIFO_AW_MAX = 10;

  // Number of entries for a given pointer width.
  function automatic int dfifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Occupancy counter width: must represent 0..DEPTH inclusive.
  function automatic int dfifo_level_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic bit dfifo_params_ok(input int data_width,
                                         input int addr_width,
                                         input int out_reg,
                                         input int almost_full_num,
                                         input int almost_empty_num);
    bit ok;
    ok = 1'b1;
    if (data_width < DFIFO_DW_MIN || data_width > DFIFO_DW_MAX) ok = 1'b0;
    if (addr_width < DFIFO_AW_MIN || addr_width > DFIFO_AW_MAX) ok = 1'b0;
    if (out_reg != 0 && out_reg != 1) ok = 1'b0;
    if (almost_full_num < 1 || almost_full_num > dfifo_depth(addr_width)) ok = 1'b0;
    if (almost_empty_num < 0 || almost_empty_num > dfifo_depth(addr_width) - 1) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/dfifo_sdpram.sv
// dfifo_sdpram -- simple dual-port RAM, DEPTH x DATA_WIDTH.
// One synchronous write port, one synchronous read port with 1-cycle latency.
// Contents and the read register are intentionally not reset.
//   clk      : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_re     : read enable (o_rdata only changes when i_re was high)
//   i_raddr  : read address
//   o_rdata  : read data, valid the cycle after i_re
module dfifo_sdpram
  import dfifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = dfifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dfifo_sync_wl.sv
// dfifo_sync_wl -- single-clock FIFO with registered water level and
// almost-full / almost-empty flags.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   clr                 : synchronous flush (pointers, count, in-flight reads)
//   wr_en, wr_data      : write request and word
//   full, almost_full   : flags decoded from the registered count
//   overflow            : one-cycle pulse after a write was rejected (full)
//   rd_en               : read request
//   rd_data, rd_valid   : popped word and its qualifier (1 or 2 cycles later)
//   empty, almost_empty : flags decoded from the registered count
//   underflow           : one-cycle pulse after a read was rejected (empty)
//   water_level         : current occupancy 0..DEPTH
//
// Handshake: a write is taken on a rising edge where wr_en=1, full=0, clr=0;
// a read is taken on a rising edge where rd_en=1, empty=0, clr=0. full/empty
// act as the inverse of "ready"; a request against a not-ready side is
// dropped and reported one cycle later via overflow/underflow. rd_valid is a
// pure strobe: there is no backpressure on the read data path.
module dfifo_sync_wl
  import dfifo_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 4,
  parameter int OUT_REG          = 1,
  parameter int ALMOST_FULL_NUM  = 14,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   water_level
);

  localparam int LW = dfifo_level_width(ADDR_WIDTH);
  localparam logic [LW-1:0] C_DEPTH = LW'(dfifo_depth(ADDR_WIDTH));
  localparam logic [LW-1:0] C_AFULL = LW'(ALMOST_FULL_NUM);
  localparam logic [LW-1:0] C_AEMPTY = LW'(ALMOST_EMPTY_NUM);

  if (!dfifo_params_ok(DATA_WIDTH, ADDR_WIDTH, OUT_REG,
                       ALMOST_FULL_NUM, ALMOST_EMPTY_NUM)) begin : g_param_check
    $error("dfifo_sync_wl: parameter out of range");
  end

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [LW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  r_v1;      // RAM read register holds a popped word
  logic                  r_v2;      // output register holds a popped word
  logic [DATA_WIDTH-1:0] r_hold;    // output register / last delivered word
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH-1:0] w_ram_q;

  // Flags come from the registered count only, never from the requests.
  assign full         = (r_count == C_DEPTH);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= C_AFULL);
  assign almost_empty = (r_count <= C_AEMPTY);
  assign water_level  = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  assign w_wr_acc = wr_en & ~full  & ~clr;
  assign w_rd_acc = rd_en & ~empty & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= wr_en & full;
      r_underflow <= rd_en & empty;
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Read pipeline. With OUT_REG=0 the word is shown straight from the RAM
  // while r_v1 is high and then latched into r_hold so rd_data holds it;
  // that latch must happen even during clr because the word was already
  // presented. With OUT_REG=1 r_hold is the output stage, so clr must stop
  // the capture of a word that will never be flagged valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_hold <= '0;
    end else begin
      r_v1 <= w_rd_acc;
      r_v2 <= r_v1 & ~clr;
      if (r_v1 && (OUT_REG == 0 || !clr)) r_hold <= w_ram_q;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    assign rd_data  = r_hold;
    assign rd_valid = r_v2;
  end else begin : g_out_direct
    assign rd_data  = r_v1 ? w_ram_q : r_hold;
    assign rd_valid = r_v1;
  end

  dfifo_sdpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (wr_data),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_q)
  );

endmodule

// File: tb/tb_dfifo_sync_wl.sv
// tb_dfifo_sync_wl -- directed + random bench for dfifo_sync_wl.
// Two instances share the same stimulus: u_dut1 (OUT_REG=1) and u_dut0
// (OUT_REG=0). A reference queue models FIFO contents; popped words are
// pushed to per-instance expected queues and compared when the bench
// expects rd_valid.
module tb_dfifo_sync_wl;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFN   = 14;
  localparam int AEN   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          clr = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;

  logic          full1, afull1, ovf1, rdv1, empty1, aempty1, udf1;
  logic [DW-1:0] rdd1;
  logic [AW:0]   wl1;
  logic          full0, afull0, ovf0, rdv0, empty0, aempty0, udf0;
  logic [DW-1:0] rdd0;
  logic [AW:0]   wl0;

  dfifo_sync_wl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1),
                  .ALMOST_FULL_NUM(AFN), .ALMOST_EMPTY_NUM(AEN)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .full(full1), .almost_full(afull1), .overflow(ovf1), .rd_en(rd_en),
    .rd_data(rdd1), .rd_valid(rdv1), .empty(empty1), .almost_empty(aempty1),
    .underflow(udf1), .water_level(wl1)
  );

  dfifo_sync_wl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0),
                  .ALMOST_FULL_NUM(AFN), .ALMOST_EMPTY_NUM(AEN)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .full(full0), .almost_full(afull0), .overflow(ovf0), .rd_en(rd_en),
    .rd_data(rdd0), .rd_valid(rdv0), .empty(empty0), .almost_empty(aempty0),
    .underflow(udf0), .water_level(wl0)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_q[$];       // words stored in the FIFO
  logic [DW-1:0] exp_q1[$];    // words still to be delivered by u_dut1
  logic [DW-1:0] exp_q0[$];    // words still to be delivered by u_dut0
  int            m_count = 0;
  logic          e_v0 = 1'b0;  // expected rd_valid, 1-cycle latency
  logic          e_v1 = 1'b0;  // expected rd_valid, 2-cycle latency
  logic          e_ovf = 1'b0;
  logic          e_udf = 1'b0;
  logic [DW-1:0] last0 = '0;
  logic [DW-1:0] last1 = '0;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q0.delete();
    exp_q1.delete();
    m_count = 0;
    e_v0 = 1'b0;
    e_v1 = 1'b0;
    e_ovf = 1'b0;
    e_udf = 1'b0;
    last0 = '0;
    last1 = '0;
  endtask

  task automatic check_flags(input string tag);
    logic e_full, e_empty, e_af, e_ae;
    e_full  = (m_count == DEPTH);
    e_empty = (m_count == 0);
    e_af    = (m_count >= AFN);
    e_ae    = (m_count <= AEN);
    chk({tag, " wl1"},     DW'(wl1), DW'(m_count));
    chk({tag, " wl0"},     DW'(wl0), DW'(m_count));
    chk({tag, " full1"},   DW'(full1), DW'(e_full));
    chk({tag, " full0"},   DW'(full0), DW'(e_full));
    chk({tag, " empty1"},  DW'(empty1), DW'(e_empty));
    chk({tag, " empty0"},  DW'(empty0), DW'(e_empty));
    chk({tag, " afull1"},  DW'(afull1), DW'(e_af));
    chk({tag, " afull0"},  DW'(afull0), DW'(e_af));
    chk({tag, " aempty1"}, DW'(aempty1), DW'(e_ae));
    chk({tag, " aempty0"}, DW'(aempty0), DW'(e_ae));
    chk({tag, " ovf1"},    DW'(ovf1), DW'(e_ovf));
    chk({tag, " ovf0"},    DW'(ovf0), DW'(e_ovf));
    chk({tag, " udf1"},    DW'(udf1), DW'(e_udf));
    chk({tag, " udf0"},    DW'(udf0), DW'(e_udf));
  endtask

  task automatic check_read(input string tag);
    logic [DW-1:0] w;
    chk({tag, " rdv1"}, DW'(rdv1), DW'(e_v1));
    chk({tag, " rdv0"}, DW'(rdv0), DW'(e_v0));
    if (e_v1) begin
      w = exp_q1.pop_front();
      last1 = w;
    end
    chk({tag, " rdd1"}, rdd1, last1);
    if (e_v0) begin
      w = exp_q0.pop_front();
      last0 = w;
    end
    chk({tag, " rdd0"}, rdd0, last0);
  endtask

  task automatic check_reset(input string tag);
    model_reset();
    check_flags(tag);
    check_read(tag);
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, let the edge happen, advance the model
  // with the pre-edge state, then sample 1 time unit after the edge.
  task automatic cycle(input string tag, input logic we, input logic [DW-1:0] wd,
                       input logic re, input logic c);
    logic acc_w, acc_r, old_v0;
    logic [DW-1:0] w;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    clr     = c;
    acc_w = we && !c && (m_count < DEPTH);
    acc_r = re && !c && (m_count > 0);
    @(posedge clk);
    #1;
    old_v0 = e_v0;
    if (c) begin
      m_q.delete();
      exp_q0.delete();
      exp_q1.delete();
      m_count = 0;
      e_v0 = 1'b0;
      e_v1 = 1'b0;
      e_ovf = 1'b0;
      e_udf = 1'b0;
    end else begin
      e_ovf = we && (m_count == DEPTH);
      e_udf = re && (m_count == 0);
      if (acc_r) begin
        w = m_q.pop_front();
        exp_q0.push_back(w);
        exp_q1.push_back(w);
      end
      if (acc_w) m_q.push_back(wd);
      m_count = m_count + int'(acc_w) - int'(acc_r);
      e_v1 = old_v0;
      e_v0 = acc_r;
    end
    check_flags(tag);
    check_read(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    idle("post_reset", 2);

    // Fill 1..16, then one rejected write
    for (int i = 1; i <= DEPTH; i++) cycle("fill", 1'b1, DW'(i), 1'b0, 1'b0);
    cycle("overflow_wr", 1'b1, 32'hAA, 1'b0, 1'b0);
    idle("overflow_drop", 1);

    // Drain 16, then one rejected read
    for (int i = 1; i <= DEPTH; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0);
    cycle("underflow_rd", 1'b0, '0, 1'b1, 1'b0);
    idle("underflow_drop", 3);

    // Simultaneous read/write at count 8, pointers wrap
    for (int i = 0; i < 8; i++) cycle("pre8", 1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle("rw8", 1'b1, $urandom, 1'b1, 1'b0);

    // Reach 10, put a read in flight, then clr with wr_en/rd_en high
    cycle("to9", 1'b1, $urandom, 1'b0, 1'b0);
    cycle("to10", 1'b1, $urandom, 1'b0, 1'b0);
    cycle("inflight", 1'b1, $urandom, 1'b1, 1'b0);
    cycle("clr", 1'b1, $urandom, 1'b1, 1'b1);
    idle("after_clr", 3);

    // Write into empty then read it back immediately
    cycle("wr_empty", 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    cycle("rd_next", 1'b0, '0, 1'b1, 1'b0);
    idle("rd_next_drain", 3);

    // Random traffic including full/empty edges and occasional clr
    for (int i = 0; i < 300; i++) begin
      cycle("random", ($urandom_range(0, 99) < 55), $urandom,
            ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 3));
    end

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 6; i++) cycle("burst", 1'b1, $urandom, (i > 2), 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset("async_reset");
    @(posedge clk);
    #1 check_reset("reset_hold");
    rst_n = 1'b1;
    idle("after_async", 2);
    for (int i = 1; i <= 4; i++) cycle("refill", 1'b1, DW'(i * 3), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle("redrain", 1'b0, '0, 1'b1, 1'b0);
    idle("final", 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dfifo_sync_wl.md
DFIFO_SYNC_WL -- requirements
Module: dfifo_sync_wl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data word width in bits (1..256).
REQ-002 Parameter ADDR_WIDTH, default 4, log2 of depth (4..10); DEPTH = 2**ADDR_WIDTH.
REQ-003 Parameter OUT_REG, default 1, 1 adds an output register stage after the RAM read.
REQ-004 Parameter ALMOST_FULL_NUM, default 14, almost_full threshold (1..DEPTH).
REQ-005 Parameter ALMOST_EMPTY_NUM, default 4, almost_empty threshold (0..DEPTH-1).
REQ-006 clk  input  1  the single clock; all logic on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 clr  input  1  synchronous flush.
REQ-009 wr_en  input  1  write request.
REQ-010 wr_data  input  DATA_WIDTH  write word.
REQ-011 full  output  1  no free entry.
REQ-012 almost_full  output  1  occupancy >= ALMOST_FULL_NUM.
REQ-013 overflow  output  1  one-cycle pulse on a rejected write.
REQ-014 rd_en  input  1  read request.
REQ-015 rd_data  output  DATA_WIDTH  read word.
REQ-016 rd_valid  output  1  rd_data carries a popped word this cycle.
REQ-017 empty  output  1  no stored entry.
REQ-018 almost_empty  output  1  occupancy <= ALMOST_EMPTY_NUM.
REQ-019 underflow  output  1  one-cycle pulse on a rejected read.
REQ-020 water_level  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Function
REQ-021 A write SHALL be accepted when wr_en=1, full=0 and clr=0; a write while full SHALL be dropped and SHALL raise overflow for the following cycle.
REQ-022 A read SHALL be accepted when rd_en=1, empty=0 and clr=0; a read while empty SHALL be ignored and SHALL raise underflow for the following cycle.
REQ-023 Simultaneous write and read when 0<count<DEPTH SHALL both be accepted, count unchanged; when full only the read SHALL be accepted; when empty only the write SHALL be accepted.
REQ-024 water_level SHALL be a registered counter updated on the edge of acceptance; full, empty, almost_full and almost_empty SHALL be decoded from that registered count only.
REQ-025 Read data SHALL appear on rd_data with rd_valid=1 exactly 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) after the edge accepting the read; rd_data SHALL hold its last value while rd_valid=0.
REQ-026 Words SHALL be returned in write order; write and read pointers SHALL be ADDR_WIDTH bits and wrap from DEPTH-1 to 0.
REQ-027 clr=1 SHALL zero both pointers and the count, cancel in-flight rd_valid, and take priority over a same-cycle wr_en/rd_en, which SHALL raise no overflow/underflow.
REQ-028 A write to an empty FIFO SHALL be readable (empty=0) on the cycle after its acceptance edge; no read-during-write bypass is required.

Reset
REQ-029 While rst_n=0: water_level=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rd_valid=0, rd_data=0, pointers=0, all asynchronously.
REQ-030 RAM contents SHALL NOT be reset; deassertion of rst_n SHALL be used synchronously by the surrounding logic, and an in-flight read SHALL be discarded.

Structure
REQ-031 A shared package dfifo_pkg SHALL hold the depth and level-width derivation functions and the parameter range limits, with an elaboration-time check of REQ-001..REQ-005.
REQ-032 Storage SHALL be one sub-module dfifo_sdpram: a simple dual-port RAM, DEPTH x DATA_WIDTH, synchronous write, synchronous 1-cycle read, no reset.

Verification
REQ-033 Defaults, rst_n low then high -> empty=1, almost_empty=1, water_level=0, all other outputs 0.
REQ-034 Write 1..16 back-to-back -> almost_full from the 14th write, full=1 and water_level=16 after the 16th; a 17th write of 0xAA -> overflow pulse for 1 cycle, count stays 16.
REQ-035 Then read 16 back-to-back, OUT_REG=1 -> rd_data=1..16 in order with rd_valid 2 cycles after each read; a 17th read -> underflow pulse, empty=1; repeat with OUT_REG=0 -> 1-cycle latency.
REQ-036 At count 8, rd_en=wr_en=1 for 20 cycles -> water_level stays 8, output sequence continuous, pointers wrap without loss.
REQ-037 At count 10 with wr_en=1, pulse clr -> next cycle water_level=0, empty=1, no overflow, pending rd_valid dropped.
REQ-038 rst_n low mid-burst between clock edges -> all outputs reach reset values before the next edge.
